// File: rtl/od_serial_tx_if.sv
// Transmit request channel of od_serial_tx: payload plus valid/ready handshake.
// No logic or latency of its own. The master holds tx_valid until the slave raises tx_ready.
interface od_serial_tx_if #(
  parameter int DATA_W = 8
) ();
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/od_serial_tx.sv
// Open-drain wired-AND serial transmitter with readback arbitration: start, DATA_W bits LSB first, stop.
// Frame starts after IDLE_CLKS high cycles. tx_ready is high only while idle, so one frame is in flight at a time.
module od_serial_tx #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int IDLE_CLKS    = 16
) (
  input  logic          clk,
  input  logic          rst,
  od_serial_tx_if.slave tx,
  input  logic          line_in,
  output logic          line_drive_low,
  output logic          busy,
  output logic          done,
  output logic          lost
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IW = $clog2(IDLE_CLKS + 1);
  localparam int BW = $clog2(DATA_W + 1);

  localparam logic [CW-1:0] CYC_LAST   = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CYC_SAMPLE = CW'(CLKS_PER_BIT / 2);
  localparam logic [IW-1:0] IDLE_LAST  = IW'(IDLE_CLKS - 1);
  localparam logic [BW-1:0] BIT_LAST   = BW'(DATA_W - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_IDLE = 3'd1,
    START     = 3'd2,
    DATA      = 3'd3,
    STOP      = 3'd4
  } state_t;

  state_t            state;
  logic [1:0]        sync_q;
  logic              line_s;
  logic [IW-1:0]     idle_cnt;
  logic [CW-1:0]     cyc_cnt;
  logic [BW-1:0]     bit_idx;
  logic [DATA_W-1:0] shreg;
  logic [DATA_W-1:0] sh_next;
  logic              ready_q;

  assign line_s      = sync_q[1];
  assign sh_next     = shreg >> 1;
  assign busy        = (state != IDLE);
  assign tx.tx_ready = ready_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q         <= 2'b11;
      state          <= IDLE;
      idle_cnt       <= '0;
      cyc_cnt        <= '0;
      bit_idx        <= '0;
      shreg          <= '0;
      ready_q        <= 1'b1;
      line_drive_low <= 1'b0;
      done           <= 1'b0;
      lost           <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], line_in};
      done   <= 1'b0;
      lost   <= 1'b0;
      case (state)
        IDLE: begin
          // ready re-arms one cycle after a frame ends, so the pulse cycle never accepts
          ready_q <= 1'b1;
          if (tx.tx_valid && ready_q) begin
            shreg    <= tx.tx_data;
            idle_cnt <= '0;
            ready_q  <= 1'b0;
            state    <= WAIT_IDLE;
          end
        end
        WAIT_IDLE: begin
          if (!line_s) begin
            idle_cnt <= '0;
          end else if (idle_cnt == IDLE_LAST) begin
            cyc_cnt        <= '0;
            line_drive_low <= 1'b1;
            state          <= START;
          end else begin
            idle_cnt <= idle_cnt + 1'b1;
          end
        end
        START: begin
          if (cyc_cnt == CYC_LAST) begin
            cyc_cnt        <= '0;
            bit_idx        <= '0;
            line_drive_low <= ~shreg[0];
            state          <= DATA;
          end else begin
            cyc_cnt <= cyc_cnt + 1'b1;
          end
        end
        DATA: begin
          // only a released bit can be overridden by another driver
          if (cyc_cnt == CYC_SAMPLE && shreg[0] && !line_s) begin
            cyc_cnt        <= '0;
            line_drive_low <= 1'b0;
            lost           <= 1'b1;
            state          <= IDLE;
          end else if (cyc_cnt == CYC_LAST) begin
            cyc_cnt <= '0;
            if (bit_idx == BIT_LAST) begin
              line_drive_low <= 1'b0;
              state          <= STOP;
            end else begin
              bit_idx        <= bit_idx + 1'b1;
              shreg          <= sh_next;
              line_drive_low <= ~sh_next[0];
            end
          end else begin
            cyc_cnt <= cyc_cnt + 1'b1;
          end
        end
        STOP: begin
          if (cyc_cnt == CYC_SAMPLE && !line_s) begin
            cyc_cnt        <= '0;
            line_drive_low <= 1'b0;
            lost           <= 1'b1;
            state          <= IDLE;
          end else if (cyc_cnt == CYC_LAST) begin
            cyc_cnt <= '0;
            done    <= 1'b1;
            state   <= IDLE;
          end else begin
            cyc_cnt <= cyc_cnt + 1'b1;
          end
        end
        default: begin
          line_drive_low <= 1'b0;
          state          <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_od_serial_tx.sv
// Directed bench for od_serial_tx (DATA_W=8, CLKS_PER_BIT=4, IDLE_CLKS=4) on a modelled wired-AND line.
// Outputs are sampled 1 time unit after each rising edge; the line reads low when the DUT or the external driver pulls.
module tb_od_serial_tx;

  localparam int DW   = 8;
  localparam int CPB  = 4;
  localparam int IDLE = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ext_low = 1'b0;
  logic line_in;
  logic line_drive_low;
  logic busy;
  logic done;
  logic lost;

  int errors = 0;
  int checks = 0;

  od_serial_tx_if #(.DATA_W(DW)) tx_if ();

  od_serial_tx #(
    .DATA_W       (DW),
    .CLKS_PER_BIT (CPB),
    .IDLE_CLKS    (IDLE)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .tx             (tx_if.slave),
    .line_in        (line_in),
    .line_drive_low (line_drive_low),
    .busy           (busy),
    .done           (done),
    .lost           (lost)
  );

  assign line_in = ~line_drive_low & ~ext_low;

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic send(input logic [DW-1:0] data);
    tx_if.tx_data  = data;
    tx_if.tx_valid = 1'b1;
    tick();
    tx_if.tx_valid = 1'b0;
    chk_eq("accept", {busy, tx_if.tx_ready}, 2'b10);
  endtask

  task automatic wait_start();
    int n;
    n = 0;
    while (!line_drive_low && n < 100) begin
      tick();
      n++;
    end
    chk_eq("start_wait", n, IDLE);
  endtask

  // Called at the sample where the start bit has just begun.
  task automatic check_frame(input logic [DW-1:0] data, input int force_bit, input int lose_bit);
    logic [DW+1:0] pat;
    int n;
    pat = {1'b0, ~data, 1'b1};
    n = (lose_bit >= 0) ? CPB*(lose_bit+1) + CPB/2 + 1 : CPB*(DW+2);
    for (int i = 0; i < n; i++) begin
      ext_low = (force_bit >= 0) && (i/CPB == force_bit + 1);
      chk_eq("frame_bit", {done, lost, line_drive_low}, {2'b00, pat[i/CPB]});
      tick();
    end
    ext_low = 1'b0;
    if (lose_bit >= 0) begin
      chk_eq("lost_pulse", {done, lost, line_drive_low, tx_if.tx_ready, busy}, 5'b01000);
      tick();
      chk_eq("lost_after", {done, lost, line_drive_low, tx_if.tx_ready}, 4'b0001);
      begin
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
          tick();
          seen = seen | done | line_drive_low;
        end
        chk_eq("no_done_after_loss", seen, 1'b0);
      end
    end else begin
      chk_eq("done_pulse", {done, lost, line_drive_low, tx_if.tx_ready, busy}, 5'b10000);
      tick();
      chk_eq("done_after", {done, lost, tx_if.tx_ready, busy}, 4'b0010);
    end
  endtask

  initial begin
    tx_if.tx_data  = '0;
    tx_if.tx_valid = 1'b0;

    // reset with idle line
    repeat (3) tick();
    chk_eq("reset_in", {tx_if.tx_ready, line_drive_low, busy, done, lost}, 5'b10000);
    rst = 1'b0;
    tick();
    chk_eq("reset_out", {tx_if.tx_ready, line_drive_low, busy, done, lost}, 5'b10000);

    // normal frame
    send(8'hA5);
    wait_start();
    check_frame(8'hA5, -1, -1);

    // idle gating: line held low for 10 cycles after acceptance
    ext_low = 1'b1;
    send(8'h5A);
    begin
      logic early;
      early = 1'b0;
      for (int i = 1; i <= 15; i++) begin
        tick();
        early = early | line_drive_low;
        if (i == 10) ext_low = 1'b0;
      end
      chk_eq("gate_hold", early, 1'b0);
      tick();
      chk_eq("gate_start", line_drive_low, 1'b1);
    end
    check_frame(8'h5A, -1, -1);

    // external low during a bit we drive low ourselves is not a collision
    send(8'h01);
    wait_start();
    check_frame(8'h01, 1, -1);

    // external low during a released bit loses arbitration
    send(8'h02);
    wait_start();
    check_frame(8'h02, 1, 1);

    // reset during data bit 3 of an all-zero frame
    send(8'h00);
    wait_start();
    begin
      logic drv_ok;
      drv_ok = 1'b1;
      for (int i = 0; i < CPB*4 + 1; i++) begin
        tick();
        drv_ok = drv_ok & line_drive_low;
      end
      chk_eq("mid_drive", drv_ok, 1'b1);
    end
    rst = 1'b1;
    tick();
    chk_eq("mid_reset", {line_drive_low, tx_if.tx_ready, busy, done, lost}, 5'b01000);
    rst = 1'b0;
    begin
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < 45; i++) begin
        tick();
        seen = seen | done | lost | line_drive_low;
      end
      chk_eq("mid_quiet", seen, 1'b0);
    end

    // back-to-back with tx_valid held; data changed while busy must not be picked up
    tx_if.tx_data  = 8'h3C;
    tx_if.tx_valid = 1'b1;
    tick();
    chk_eq("b2b_accept0", {busy, tx_if.tx_ready}, 2'b10);
    tx_if.tx_data = 8'hC3;
    wait_start();
    check_frame(8'h3C, -1, -1);
    tick();
    chk_eq("b2b_accept1", {busy, tx_if.tx_ready}, 2'b10);
    tx_if.tx_valid = 1'b0;
    wait_start();
    check_frame(8'hC3, -1, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
